// File: rtl/elastic_pipe.sv
// elastic_pipe: DEPTH-stage valid/ready pipeline with bubble collapsing,
// synchronous flush and a registered occupancy count.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   in_valid/in_data    producer beat; in_ready accepts it this cycle
//   out_valid/out_data  beat held in the last stage; out_ready consumes it
//   flush               drops every in-flight beat at the next edge
//   occupancy           number of valid beats currently held
//
// Optional feature macro: ELASTIC_PIPE_SKID_EN
//   Adds a one-entry skid register in front of stage 0 so that in_ready
//   comes from a register instead of the out_ready backpressure chain.
module elastic_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int OCCW  = $clog2(DEPTH + 2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             flush,
    output logic [OCCW-1:0]  occupancy
);

    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [OCCW-1:0]  r_occ;

    logic [DEPTH-1:0] w_acc;
    logic             w_hole;
    logic [DEPTH-1:0] w_up_valid;
    logic [WIDTH-1:0] w_up_data [DEPTH];
    logic             w_src_valid;
    logic [WIDTH-1:0] w_src_data;
    logic             w_in_fire;
    logic             w_out_fire;

    // A stage accepts when the consumer takes the last beat or when any
    // stage at or beyond it is empty, since the beats ahead then shift.
    always_comb begin
        w_hole = 1'b0;
        w_acc  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_hole   = w_hole | ~r_valid[i];
            w_acc[i] = w_hole | out_ready;
        end
    end

    assign out_valid  = r_valid[DEPTH-1] & ~flush;
    assign out_data   = r_data[DEPTH-1];
    assign w_out_fire = out_valid & out_ready;
    assign w_in_fire  = in_valid & in_ready;
    assign occupancy  = r_occ;

`ifdef ELASTIC_PIPE_SKID_EN
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;

    assign in_ready = ~r_skid_valid & ~flush;

    // The skid entry always drains before new input; in_ready is low while
    // it is occupied, so the two sources never compete.
    assign w_src_valid = r_skid_valid | w_in_fire;
    assign w_src_data  = r_skid_valid ? r_skid_data : in_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (flush) begin
            r_skid_valid <= 1'b0;
        end else if (r_skid_valid) begin
            if (w_acc[0]) begin
                r_skid_valid <= 1'b0;
            end
        end else if (w_in_fire && !w_acc[0]) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= in_data;
        end
    end
`else
    assign in_ready    = w_acc[0] & ~flush;
    assign w_src_valid = w_in_fire;
    assign w_src_data  = in_data;
`endif

    always_comb begin
        w_up_valid[0] = w_src_valid;
        w_up_data[0]  = w_src_data;
        for (int i = 1; i < DEPTH; i++) begin
            w_up_valid[i] = r_valid[i-1];
            w_up_data[i]  = r_data[i-1];
        end
    end

    // A stage that accepts takes whatever its upstream holds; if the
    // upstream is empty the stage goes empty (its own beat moved on).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_acc[i]) begin
                    r_valid[i] <= w_up_valid[i];
                    if (w_up_valid[i]) begin
                        r_data[i] <= w_up_data[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_occ <= '0;
        end else begin
            case ({w_in_fire, w_out_fire})
                2'b10:   r_occ <= r_occ + OCCW'(1);
                2'b01:   r_occ <= r_occ - OCCW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: tb/tb_elastic_pipe.sv
// tb_elastic_pipe: directed stimulus for elastic_pipe, checked every cycle
// against a beat-queue model plus hand-computed literal expectations.
module tb_elastic_pipe;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int OW = $clog2(D + 2);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready = 1'b0;
    logic          flush = 1'b0;
    logic [OW-1:0] occupancy;

    always #5 clk = ~clk;

    elastic_pipe #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .flush     (flush),
        .occupancy (occupancy)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [W-1:0] d;
        int           p;
    } beat_t;

    beat_t        mq [$];
    bit           sk_v = 1'b0;
    logic [W-1:0] sk_d = '0;
    bit           armed = 1'b0;
    logic [W-1:0] got_q [$];
    int           got_c [$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: each held beat has a position 0..D-1; every edge a beat
    // advances one place unless the beat ahead blocks it. The beat at
    // position D-1 is the one presented to the consumer.
    always @(negedge clk) begin : mdl
        bit    ov, ofire, free, ir, ifire;
        int    prevp, s;
        int    np [$];
        beat_t nb;
        np.delete();
        cyc++;
        ov    = !flush && mq.size() > 0 && mq[0].p == D - 1;
        ofire = ov && out_ready;
        s     = ofire ? 1 : 0;
        prevp = D;
        for (int k = s; k < mq.size(); k++) begin
            np.push_back((mq[k].p + 1 < prevp) ? mq[k].p + 1 : prevp - 1);
            prevp = np[np.size()-1];
        end
        free = (np.size() == 0) || (np[np.size()-1] > 0);
`ifdef ELASTIC_PIPE_SKID_EN
        ir = !flush && !sk_v;
`else
        ir = !flush && free;
`endif
        ifire = in_valid && ir;
        if (armed) begin
            chk("in_ready", in_ready, ir);
            chk("out_valid", out_valid, ov);
            chk("occupancy", occupancy, mq.size() + int'(sk_v));
            if (ov) chk("out_data", out_data, mq[0].d);
            if (out_valid === 1'b1 && out_ready) begin
                got_q.push_back(out_data);
                got_c.push_back(cyc);
            end
        end
        if (reset) begin
            mq.delete();
            sk_v  = 1'b0;
            armed = 1'b1;
        end else if (armed) begin
            if (flush) begin
                mq.delete();
                sk_v = 1'b0;
            end else begin
                if (ofire) void'(mq.pop_front());
                for (int k = 0; k < mq.size(); k++) begin
                    nb      = mq[k];
                    nb.p    = np[k];
                    mq[k]   = nb;
                end
`ifdef ELASTIC_PIPE_SKID_EN
                if (sk_v && free) begin
                    nb.d = sk_d; nb.p = 0;
                    mq.push_back(nb);
                    sk_v = 1'b0;
                end else if (ifire) begin
                    if (free) begin
                        nb.d = in_data; nb.p = 0;
                        mq.push_back(nb);
                    end else begin
                        sk_v = 1'b1;
                        sk_d = in_data;
                    end
                end
`else
                if (ifire) begin
                    nb.d = in_data; nb.p = 0;
                    mq.push_back(nb);
                end
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d);
        in_valid = v;
        in_data  = d;
        #1;
    endtask

    task automatic drain(input string nm, input int n);
        int b = 0;
        while (got_q.size() < n && b < 100) begin
            tick();
            b++;
        end
        chk({nm, "_count"}, got_q.size(), n);
    endtask

    // Expected output stream: base, base+1, ... n beats, back to back.
    task automatic check_seq(input string nm, input logic [W-1:0] base,
                             input int n, input bit gapless);
        for (int k = 0; k < n; k++) begin
            if (k < got_q.size()) chk(nm, got_q[k], 32'(base + W'(k)));
            else chk(nm, 32'hFFFF_FFFF, 32'(base + W'(k)));
            if (gapless && k > 0 && k < got_c.size())
                chk({nm, "_gap"}, got_c[k] - got_c[k-1], 1);
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_in_ready", in_ready, 1);

        // stream 0x01..0x10, consumer always ready
        got_q.delete(); got_c.delete();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, W'(i + 1));
            chk("t1_in_ready", in_ready, 1);
            if (i == 3) chk("t1_lat_early", out_valid, 0);
            if (i == 4) begin
                chk("t1_lat_first", out_valid, 1);
                chk("t1_first_data", out_data, 8'h01);
            end
            if (i >= 4) chk("t1_occ", occupancy, 4);
            tick();
        end
        in_valid = 1'b0;
        drain("t1", 16);
        check_seq("t1_seq", 8'h01, 16, 1'b1);

`ifndef ELASTIC_PIPE_SKID_EN
        // stall with bubbles; beats pack toward the output
        tick();
        got_q.delete(); got_c.delete();
        out_ready = 1'b0;
        drive(1'b1, 8'hA0); chk("t2_ir0", in_ready, 1); tick();
        drive(1'b0, 8'h00); chk("t2_ir1", in_ready, 1); tick();
        drive(1'b1, 8'hA1); chk("t2_ir2", in_ready, 1); tick();
        drive(1'b0, 8'h00); chk("t2_ir3", in_ready, 1); tick();
        drive(1'b1, 8'hA2); chk("t2_ir4", in_ready, 1); tick();
        drive(1'b1, 8'hA3); chk("t2_ir5", in_ready, 1); tick();
        drive(1'b1, 8'hA4);
        chk("t2_full_ir", in_ready, 0);
        chk("t2_full_occ", occupancy, 4);
        tick();
        #1;
        chk("t2_hold_ir", in_ready, 0);
        chk("t2_hold_data", out_data, 8'hA0);
        out_ready = 1'b1;
        #1;
        chk("t2_rel_ir", in_ready, 1);
        tick();
        in_valid = 1'b0;
        drain("t2", 5);
        check_seq("t2_seq", 8'hA0, 5, 1'b1);
`endif

        // full pipe, simultaneous in and out
        tick();
        got_q.delete(); got_c.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'hB0 + W'(i));
            tick();
        end
        out_ready = 1'b1;
        for (int i = 4; i < 10; i++) begin
            drive(1'b1, 8'hB0 + W'(i));
            chk("t3_ir", in_ready, 1);
            chk("t3_occ", occupancy, 4);
            tick();
        end
        in_valid = 1'b0;
        drain("t3", 10);
        check_seq("t3_seq", 8'hB0, 10, 1'b1);

        // flush with 3 beats held
        tick();
        got_q.delete(); got_c.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'hC0 + W'(i));
            tick();
        end
        flush = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 8'hC3);
        chk("t4_fl_ir", in_ready, 0);
        chk("t4_fl_ov", out_valid, 0);
        chk("t4_fl_occ", occupancy, 3);
        tick();
        flush = 1'b0;
        drive(1'b0, 8'h00);
        chk("t4_post_ov", out_valid, 0);
        chk("t4_post_occ", occupancy, 0);
        drive(1'b1, 8'hD0);
        chk("t4_d0_ir", in_ready, 1);
        tick();
        in_valid = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            #1;
            if (j < 4) chk("t4_lat_early", out_valid, 0);
            else begin
                chk("t4_lat", out_valid, 1);
                chk("t4_lat_data", out_data, 8'hD0);
            end
            tick();
        end
        drain("t4", 1);
        check_seq("t4_seq", 8'hD0, 1, 1'b0);

        // reset while full and stalled
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'hE0 + W'(i));
            tick();
        end
        #1;
        chk("t5_pre_occ", occupancy, 4);
        do_reset();
        #1;
        chk("t5_out_valid", out_valid, 0);
        chk("t5_out_data", out_data, 0);
        chk("t5_occ", occupancy, 0);
        chk("t5_in_ready", in_ready, 1);

`ifdef ELASTIC_PIPE_SKID_EN
        // skid capture when the pipe is full
        tick();
        got_q.delete(); got_c.delete();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'hF0 + W'(i));
            tick();
        end
        drive(1'b1, 8'h55);
        chk("t6_ir", in_ready, 1);
        tick();
        drive(1'b0, 8'h00);
        chk("t6_sk_ir", in_ready, 0);
        chk("t6_sk_occ", occupancy, 5);
        out_ready = 1'b1;
        drain("t6", 5);
        check_seq("t6_seq", 8'hF0, 4, 1'b1);
        if (got_q.size() > 4) chk("t6_skid_data", got_q[4], 8'h55);
        else chk("t6_skid_data", 32'hFFFF_FFFF, 8'h55);
`endif

        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
